// File: rtl/is_uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, start-bit validation, centre sampling,
// valid/ready byte output with one-cycle frame-error and overrun pulses.
module is_uart_rx #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD_RATE   = 115200,
  parameter int DATA_BITS   = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 uart_data_rx_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int IDX_W        = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_e;

  state_e                 state_q;
  logic [1:0]             sync_q;
  logic                   rx_s;
  logic [CNT_W-1:0]       cnt_q;
  logic [IDX_W-1:0]       idx_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic [DATA_BITS-1:0]   shift_d;
  logic [DATA_BITS-1:0]   data_q;
  logic                   valid_q;
  logic                   frame_err_q;
  logic                   overrun_q;
  logic                   busy_q;
  logic                   bit_end;

  // The line idles high, so the synchroniser resets to 1 to avoid a false start.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], uart_data_rx_i};
    end
  end

  assign rx_s    = sync_q[1];
  assign bit_end = (cnt_q == BIT_LAST);

  generate
    if (DATA_BITS == 1) begin : g_shift_one
      assign shift_d = rx_s;
    end else begin : g_shift_many
      assign shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      // A completing frame below overrides this clear with the new byte.
      if (valid_q && ready_i) begin
        valid_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_q <= START;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q <= '0;
            if (!rx_s) begin
              state_q <= DATA;
              idx_q   <= '0;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            shift_q <= shift_d;
            cnt_q   <= '0;
            idx_q   <= idx_q + IDX_W'(1);
            if (idx_q == IDX_LAST) begin
              state_q <= STOP;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (rx_s) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              if (!valid_q || ready_i) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= BREAK;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        BREAK: begin
          if (rx_s) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_is_uart_rx.sv
// Bench for is_uart_rx: directed frames plus random traffic, with a queue of
// expected bytes consumed by an independent output monitor.
module tb_is_uart_rx;

  localparam int CLK_HZ = 100_000_000;
  localparam int BAUD   = 460_800;
  localparam int NB     = 8;
  localparam int CPB    = CLK_HZ / BAUD;
  localparam int HALF   = CPB / 2;
  // Cycle offsets measured from the edge after which the start bit is driven.
  localparam int STOP_SAMPLE = 2 + HALF + CPB * (NB + 1);
  localparam int VALID_LAT   = STOP_SAMPLE + 1;
  localparam int GLITCH      = (HALF * 200) / 434;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_pin;
  logic          ready;
  logic [NB-1:0] data;
  logic          valid;
  logic          fe;
  logic          ov;
  logic          busy;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int valid_cycles = 0;
  int last_fe = -1;
  int last_ov = -1;
  int last_vrise = -1;
  int stable_viol = 0;
  int exp_fe = 0;
  int exp_ov = 0;
  int ready_mode = 1;
  logic [NB-1:0] exp_q[$];

  is_uart_rx #(
    .CLK_FREQ_HZ(CLK_HZ),
    .BAUD_RATE  (BAUD),
    .DATA_BITS  (NB)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .uart_data_rx_i(rx_pin),
    .data_o        (data),
    .valid_o       (valid),
    .ready_i       (ready),
    .frame_err_o   (fe),
    .overrun_o     (ov),
    .busy_o        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic chk_eq(input string name, input int act, input int req);
    chk(act == req, name, act, req);
  endtask

  // Caller is 1 time unit after a clock edge; returns in the same phase.
  task automatic send_frame(input logic [NB-1:0] b, input logic stop_bit, input int stop_len);
    for (int k = 0; k < NB + 2; k++) begin
      if (k == 0) rx_pin = 1'b0;
      else if (k == NB + 1) rx_pin = stop_bit;
      else rx_pin = b[k-1];
      repeat ((k == NB + 1) ? stop_len : CPB) @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    rx_pin = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_cyc(input int t);
    do @(negedge clk); while (cyc < t);
  endtask

  task automatic sync_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    ready_mode = 1;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    chk_eq("drain_queue_empty", exp_q.size(), 0);
    sync_edge();
  endtask

  initial begin
    int c;
    int c2;
    int r;
    int g;
    int vc0;
    int n_pulse;
    logic [NB-1:0] b;
    bit err;

    rst = 1'b1;
    rx_pin = 1'b1;
    ready = 1'b1;

    fork
      // ---------------- stimulus ----------------
      begin
        repeat (3) @(posedge clk);
        #1;
        chk_eq("reset_data", int'(data), 0);
        chk_eq("reset_valid", int'(valid), 0);
        chk_eq("reset_frame_err", int'(fe), 0);
        chk_eq("reset_overrun", int'(ov), 0);
        chk_eq("reset_busy", int'(busy), 0);
        rst = 1'b0;
        idle(5);

        // 0xA5, consumer always ready
        ready_mode = 1;
        exp_q.push_back(8'hA5);
        vc0 = valid_cycles;
        c = cyc;
        fork
          send_frame(8'hA5, 1'b1, CPB);
          begin
            wait_cyc(c + 2);
            chk_eq("a5_busy_at_t0", int'(busy), 0);
            wait_cyc(c + 3);
            chk_eq("a5_busy_at_t0p1", int'(busy), 1);
            wait_cyc(c + STOP_SAMPLE);
            chk_eq("a5_busy_at_stop", int'(busy), 1);
            wait_cyc(c + VALID_LAT);
            chk_eq("a5_busy_after_stop", int'(busy), 0);
            chk_eq("a5_valid", int'(valid), 1);
            chk_eq("a5_data", int'(data), 8'hA5);
          end
        join
        chk_eq("a5_valid_rise_cycle", last_vrise, c + VALID_LAT);
        chk_eq("a5_valid_width", valid_cycles - vc0, 1);
        chk_eq("a5_frame_err_count", fe_cnt, exp_fe);
        chk_eq("a5_overrun_count", ov_cnt, exp_ov);
        chk_eq("a5_queue_empty", exp_q.size(), 0);

        // 0x3C then 0x7E with no consumer: second byte is an overrun
        ready_mode = 0;
        idle(3);
        exp_q.push_back(8'h3C);
        exp_ov++;
        send_frame(8'h3C, 1'b1, CPB);
        c2 = cyc;
        send_frame(8'h7E, 1'b1, CPB);
        chk_eq("ovr_pulse_cycle", last_ov, c2 + VALID_LAT);
        chk_eq("ovr_count", ov_cnt, exp_ov);
        chk_eq("ovr_valid_held", int'(valid), 1);
        chk_eq("ovr_data_kept", int'(data), 8'h3C);
        chk_eq("ovr_frame_err_count", fe_cnt, exp_fe);
        drain();

        // 0x55 with a low stop bit, line held low for 20 bit times
        vc0 = valid_cycles;
        exp_fe++;
        c = cyc;
        send_frame(8'h55, 1'b0, CPB);
        repeat (20 * CPB) @(posedge clk);
        #1;
        chk_eq("brk_busy_held", int'(busy), 1);
        r = cyc;
        rx_pin = 1'b1;
        wait_cyc(r + 2);
        chk_eq("brk_busy_before_release", int'(busy), 1);
        wait_cyc(r + 3);
        chk_eq("brk_busy_after_release", int'(busy), 0);
        sync_edge();
        chk_eq("brk_frame_err_count", fe_cnt, exp_fe);
        chk_eq("brk_frame_err_cycle", last_fe, c + VALID_LAT);
        chk_eq("brk_no_valid", valid_cycles - vc0, 0);
        chk_eq("brk_overrun_count", ov_cnt, exp_ov);

        // short low glitch on an idle line
        idle(10);
        vc0 = valid_cycles;
        g = cyc;
        rx_pin = 1'b0;
        repeat (GLITCH) @(posedge clk);
        #1;
        rx_pin = 1'b1;
        wait_cyc(g + 2 + HALF);
        chk_eq("glitch_busy_at_check", int'(busy), 1);
        wait_cyc(g + 3 + HALF);
        chk_eq("glitch_back_to_idle", int'(busy), 0);
        sync_edge();
        idle(CPB);
        chk_eq("glitch_no_valid", valid_cycles - vc0, 0);
        chk_eq("glitch_frame_err_count", fe_cnt, exp_fe);
        chk_eq("glitch_overrun_count", ov_cnt, exp_ov);

        // reset in the middle of bit 4 of 0xF0, then 0x12
        chk_eq("pre_reset_data_is_3c", int'(data), 8'h3C);
        rx_pin = 1'b0;
        repeat (5 * CPB) @(posedge clk);
        #1;
        rx_pin = 1'b1;
        repeat (CPB / 2) @(posedge clk);
        #1;
        rst = 1'b1;
        sync_edge();
        rst = 1'b0;
        chk_eq("mid_reset_data", int'(data), 0);
        chk_eq("mid_reset_valid", int'(valid), 0);
        chk_eq("mid_reset_busy", int'(busy), 0);
        chk_eq("mid_reset_frame_err", int'(fe), 0);
        chk_eq("mid_reset_overrun", int'(ov), 0);
        idle(5 * CPB);
        exp_q.push_back(8'h12);
        send_frame(8'h12, 1'b1, CPB);
        drain();
        chk_eq("post_reset_frame_err_count", fe_cnt, exp_fe);

        // 0x00 then 0xFF back-to-back with a one-idle-cycle gap;
        // the consumer accepts exactly as the second byte completes
        ready_mode = 0;
        idle(3);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        n_pulse = (9 * CPB + HALF + 1) + STOP_SAMPLE;
        c = cyc;
        fork
          begin
            send_frame(8'h00, 1'b1, HALF + 1);
            send_frame(8'hFF, 1'b1, CPB);
          end
          begin
            repeat (n_pulse) @(posedge clk);
            #1;
            ready_mode = 1;
            sync_edge();
            ready_mode = 0;
            wait_cyc(c + n_pulse + 1);
            chk_eq("stream_valid_kept", int'(valid), 1);
            chk_eq("stream_new_data", int'(data), 8'hFF);
          end
        join
        chk_eq("stream_overrun_count", ov_cnt, exp_ov);
        chk_eq("stream_one_left", exp_q.size(), 1);
        drain();

        // random frames, random stop length/gap, random consumer
        ready_mode = 2;
        for (int i = 0; i < 10; i++) begin
          b = NB'($urandom_range(0, 255));
          err = ($urandom_range(0, 3) == 0);
          if (err) begin
            exp_fe++;
            send_frame(b, 1'b0, CPB);
            idle($urandom_range(1, 20));
          end else begin
            exp_q.push_back(b);
            send_frame(b, 1'b1, $urandom_range(HALF + 1, CPB));
            idle($urandom_range(0, 10));
          end
        end
        idle(CPB);
        drain();
        chk_eq("rand_frame_err_count", fe_cnt, exp_fe);
        chk_eq("rand_overrun_count", ov_cnt, exp_ov);
        chk_eq("data_stable_while_stalled", stable_viol, 0);
      end

      // ---------------- output monitor ----------------
      begin
        logic          prev_valid = 1'b0;
        logic          prev_ready = 1'b0;
        logic          prev_rst = 1'b1;
        logic [NB-1:0] prev_data = '0;
        logic [NB-1:0] want;
        forever begin
          @(negedge clk);
          if (fe) begin
            fe_cnt++;
            last_fe = cyc;
          end
          if (ov) begin
            ov_cnt++;
            last_ov = cyc;
          end
          if (valid) valid_cycles++;
          if (valid && !prev_valid) last_vrise = cyc;
          if (prev_valid && !prev_ready && !prev_rst && (!valid || data != prev_data))
            stable_viol++;
          if (valid && ready) begin
            chk(exp_q.size() > 0, "unexpected_byte", int'(data), -1);
            if (exp_q.size() > 0) begin
              want = exp_q.pop_front();
              chk_eq("rx_byte", int'(data), int'(want));
            end
          end
          prev_valid = valid;
          prev_ready = ready;
          prev_rst   = rst;
          prev_data  = data;
        end
      end

      // ---------------- consumer ready driver ----------------
      forever begin
        @(posedge clk);
        #2;
        case (ready_mode)
          0:       ready = 1'b0;
          1:       ready = 1'b1;
          default: ready = 1'($urandom_range(0, 1));
        endcase
      end

      // ---------------- watchdog ----------------
      begin
        repeat (90000) @(posedge clk);
        checks++;
        errors++;
        $display("FAIL timeout: run exceeded 90000 cycles, required completion");
      end
    join_any
    disable fork;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
